uart_rx_buffered: RTL and testbench

//   Serial receive front end of the Risco_5 SoC UART peripheral; consumes the
//   top-level rx pin. Its output feeds the memory-mapped UART register block.

---
 rtl/uart_defs.sv | 16 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_buffered.sv | 156 +++++++++++++++
 tb/tb_uart_rx_buffered.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the UART receive path.
//   - FSM state encodings (3 bits, kept as plain constants so existing
//     tooling that decodes the state debug port keeps working).
//   - Frame constants for 8N1 framing.
package uart_defs;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam int         DATA_BITS  = 8;
  localparam logic       STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received bytes.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write request and data; a push while full is accepted only
//                when a pop happens in the same cycle
//   pop        : removes the head; ignored while empty
//   dout       : head entry, combinational from storage
//   empty/full : occupancy flags
//   dropped    : one-cycle strobe, a push was refused because the FIFO was full
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             dropped
);
  import uart_defs::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  // A simultaneous pop frees the slot the push needs, so push-when-full only
  // drops the byte when nothing is leaving that cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dropped = push & full & ~pop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receive front end: 2-flop synchroniser, 8N1 frame decoder with
// mid-bit sampling, FWFT receive FIFO and sticky error flags.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   rx          : asynchronous serial input, idles high
//   read_en     : pop request for the FIFO head
//   clear       : clears frame_error and overflow
//   rx_data     : FIFO head, valid while rx_empty is low
//   rx_empty    : FIFO holds no bytes
//   rx_full     : FIFO holds FIFO_DEPTH bytes
//   frame_error : sticky, a stop bit was sampled low
//   overflow    : sticky, a good byte was dropped on a full FIFO
//   fsm_state   : current decoder state (debug)
//
// Read handshake: rx_empty low acts as "valid" for rx_data and read_en acts
// as "ready"; a byte transfers on each rising edge where read_en is high and
// rx_empty is low. read_en while rx_empty is high has no effect.
module uart_rx_buffered #(
  parameter int CLOCK_FREQ = 25000000,
  parameter int BIT_RATE   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       read_en,
  input  logic       clear,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_error,
  output logic       overflow,
  output logic [2:0] fsm_state
);
  import uart_defs::*;

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_sample;
  logic          push;
  logic          bad_stop;
  logic          dropped;

  // Synchroniser resets to the idle line level so reset never looks like a
  // start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign stop_sample = (state == STOP) && (baud_cnt == BIT_LAST);
  assign push        = stop_sample && (rx_s == STOP_LEVEL);
  assign bad_stop    = stop_sample && (rx_s != STOP_LEVEL);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          // Half a bit in: the middle of the start bit. A high line here
          // was only a glitch.
          if (baud_cnt == HALF_LAST) begin
            if (!rx_s) begin
              baud_cnt <= '0;
              bit_idx  <= '0;
              state    <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX) state <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= (rx_s == STOP_LEVEL) ? IDLE : WAIT_HIGH;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new frame.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Setting events take priority over clear so no error is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (bad_stop)   frame_error <= 1'b1;
      else if (clear) frame_error <= 1'b0;
      if (dropped)    overflow <= 1'b1;
      else if (clear) overflow <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (read_en),
    .din     (shift),
    .dout    (rx_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .dropped (dropped)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
module tb_uart_rx_buffered;

  localparam int OP_SEND  = 0;
  localparam int OP_READ  = 1;
  localparam int OP_CLEAR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       read_en = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_error;
  logic       overflow;
  logic [2:0] fsm_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic       chk_head;
    logic [7:0] head;
    logic       e;
    logic       f;
    logic       fe;
    logic       ov;
  } vec_t;

  vec_t vecs[16];

  uart_rx_buffered #(
    .CLOCK_FREQ (16),
    .BIT_RATE   (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .read_en     (read_en),
    .clear       (clear),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .frame_error (frame_error),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic chk_head, input logic [7:0] head,
                            input logic e, input logic f, input logic fe, input logic ov);
    if (chk_head) check8({tag, "_data"}, rx_data, head);
    check1({tag, "_empty"}, rx_empty, e);
    check1({tag, "_full"}, rx_full, f);
    check1({tag, "_ferr"}, frame_error, fe);
    check1({tag, "_ovf"}, overflow, ov);
  endtask

  // ---------------- drivers ----------------
  // Drives ncyc cycles of an 8N1 frame (16 clocks per bit) starting after the
  // next rising edge. read_en is pulsed in cycle pop_cycle; when chk_c >= 0
  // the push timing is checked around cycle chk_c.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int ncyc,
                            input int pop_cycle, input int chk_c);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c < 16)       rx = 1'b0;
      else if (c < 144) rx = data[(c - 16) >> 4];
      else              rx = stop_bit;
      read_en = (c == pop_cycle);
      if (chk_c >= 0 && c == chk_c - 1) check1("push_not_early", rx_empty, 1'b1);
      if (chk_c >= 0 && c == chk_c)     check1("push_on_time", rx_empty, 1'b0);
    end
    @(posedge clk); #1;
    read_en = 1'b0;
    if (stop_bit) rx = 1'b1;
  endtask

  task automatic read_pulse();
    @(posedge clk); #1; read_en = 1'b1;
    @(posedge clk); #1; read_en = 1'b0;
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{OP_SEND,  8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_READ,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SEND,  8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SEND,  8'h02, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_SEND,  8'h03, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SEND,  8'h04, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{OP_SEND,  8'h05, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{OP_READ,  8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{OP_READ,  8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{OP_READ,  8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{OP_READ,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{OP_CLEAR, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_SEND,  8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SEND,  8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_READ,  8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{OP_READ,  8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check8("reset_state", {5'd0, fsm_state}, 8'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Good frames, FIFO fill, overflow, clear, edge data patterns
    for (int i = 0; i < 16; i++) begin
      case (vecs[i].op)
        OP_SEND:  send_frame(vecs[i].data, 1'b1, 160, -1, (i == 0) ? 155 : -1);
        OP_READ:  read_pulse();
        default:  clear_pulse();
      endcase
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].chk_head, vecs[i].head,
                 vecs[i].e, vecs[i].f, vecs[i].fe, vecs[i].ov);
    end

    // Short low glitch: start bit rejected at mid-bit
    @(posedge clk); #1; rx = 1'b0;
    repeat (4) @(posedge clk);
    #1; rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check8("glitch_state", {5'd0, fsm_state}, 8'd0);
    check_outs("glitch", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0, 160, -1, -1);
    repeat (24) @(posedge clk);
    @(negedge clk);
    check8("break_state", {5'd0, fsm_state}, 8'd4);
    check_outs("break", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1; rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check8("break_release_state", {5'd0, fsm_state}, 8'd0);
    check1("break_release_ferr", frame_error, 1'b1);
    clear_pulse();
    @(negedge clk);
    check1("ferr_cleared", frame_error, 1'b0);

    // Reset in the middle of data bit 3
    send_frame(8'h11, 1'b1, 160, -1, -1);
    send_frame(8'hC3, 1'b1, 72, -1, -1);
    @(negedge clk);
    check8("midframe_state", {5'd0, fsm_state}, 8'd2);
    check1("midframe_not_empty", rx_empty, 1'b0);
    @(posedge clk); #1; reset = 1'b1; rx = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("midreset", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check8("midreset_state", {5'd0, fsm_state}, 8'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check1("after_reset_still_empty", rx_empty, 1'b1);
    send_frame(8'h5A, 1'b1, 160, -1, -1);
    @(negedge clk);
    check_outs("post_reset_rx", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    read_pulse();
    @(negedge clk);
    check1("post_reset_once", rx_empty, 1'b1);

    // Push and pop together on a full FIFO
    send_frame(8'h21, 1'b1, 160, -1, -1);
    send_frame(8'h22, 1'b1, 160, -1, -1);
    send_frame(8'h23, 1'b1, 160, -1, -1);
    send_frame(8'h24, 1'b1, 160, -1, -1);
    @(negedge clk);
    check1("full_before", rx_full, 1'b1);
    send_frame(8'h77, 1'b1, 160, 154, -1);
    @(negedge clk);
    check_outs("pushpop", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    read_pulse(); @(negedge clk); check8("pp_rd1", rx_data, 8'h23);
    read_pulse(); @(negedge clk); check8("pp_rd2", rx_data, 8'h24);
    read_pulse(); @(negedge clk); check8("pp_rd3", rx_data, 8'h77);
    read_pulse(); @(negedge clk); check1("pp_empty", rx_empty, 1'b1);

    // Read while empty is ignored
    read_pulse(); @(negedge clk);
    check_outs("underflow", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
